// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner: shadows the display word, commits it
// at frame wrap, and drives one active-low anode per slot after a dead-time gap.
module seg_scan_driver #(
  parameter int CLK_DIV  = 100000,
  parameter int DEAD     = 64,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic [3:0]  digit_hex,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [15:0]   shadow_r;
  logic [15:0]   disp_r;
  logic          slot_end_s;
  logic          wrap_s;
  logic          dead_s;
  logic          blank_s;
  logic [3:0]    nib_s;
  logic [3:0]    hex_s;
  logic [3:0]    an_s;

  // Digit k >= 1 is a leading zero when every nibble from k upward is zero.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd0:    lz_blank = 1'b0;
      2'd1:    lz_blank = (v[15:4] == 12'h000);
      2'd2:    lz_blank = (v[15:8] == 8'h00);
      2'd3:    lz_blank = (v[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd0:    nibble_sel = v[3:0];
      2'd1:    nibble_sel = v[7:4];
      2'd2:    nibble_sel = v[11:8];
      2'd3:    nibble_sel = v[15:12];
      default: nibble_sel = 4'h0;
    endcase
  endfunction

  assign slot_end_s = (cnt_r == CNT_MAX);
  assign wrap_s     = slot_end_s && (idx_r == 2'd3);

  generate
    if (DEAD == 0) begin : g_nodead
      assign dead_s = 1'b0;
    end else begin : g_dead
      assign dead_s = (cnt_r < DEAD_C);
    end
  endgenerate

  // Next-cycle digit nibble and anode pattern from the current slot position.
  always_comb begin
    nib_s   = nibble_sel(disp_r, idx_r);
    blank_s = (BLANK_LZ != 0) ? lz_blank(disp_r, idx_r) : 1'b0;
    hex_s   = blank_s ? 4'hF : nib_s;
    an_s    = 4'b1111;
    if (dead_s || blank_s) begin
      an_s = 4'b1111;
    end else begin
      case (idx_r)
        2'd0:    an_s = 4'b1110;
        2'd1:    an_s = 4'b1101;
        2'd2:    an_s = 4'b1011;
        2'd3:    an_s = 4'b0111;
        default: an_s = 4'b1111;
      endcase
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else if (slot_end_s) begin
      cnt_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Shadow capture; the wrap edge commits the shadow as it was before that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= 16'h0000;
      disp_r   <= 16'h0000;
    end else begin
      if (din_valid) begin
        shadow_r <= din;
      end
      if (wrap_s) begin
        disp_r <= shadow_r;
      end
    end
  end

  // Registered outputs, one cycle behind the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_hex  <= 4'h0;
      an         <= 4'b1111;
      frame_tick <= 1'b0;
    end else begin
      digit_hex  <= hex_s;
      an         <= an_s;
      frame_tick <= wrap_s;
    end
  end

endmodule
